load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte-address width, matching $clog2(MEM_SIZE) of data_memory.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  1  CPU request present.
REQ-006 o_req_ready  output  1  unit can accept a request.
REQ-007 i_req_we  input  1  1 = store, 0 = load.
REQ-008 i_req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 i_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
REQ-010 i_req_addr  input  ADDR_WIDTH  byte address.
REQ-011 i_req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-012 o_rsp_valid  output  1  response present.
REQ-013 i_rsp_ready  input  1  CPU accepts response.
REQ-014 o_rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 o_rsp_err  output  1  misaligned or illegal-size request.
REQ-016 o_mem_we  output  1  to data_memory i_we.
REQ-017 o_mem_addr  output  ADDR_WIDTH  to data_memory i_addr, word-aligned (bits [1:0] = 00).
REQ-018 o_mem_wdata  output  DATA_WIDTH  to data_memory i_data.
REQ-019 i_mem_rdata  input  DATA_WIDTH  from data_memory o_data; combinational read of o_mem_addr.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-021 o_req_ready SHALL be 1 exactly when state is IDLE.
REQ-022 Accept when i_req_valid & o_req_ready: latch we, size, unsigned, addr, wdata; inputs ignored afterwards until next IDLE.
REQ-023 Error check at accept: size 11, halfword with addr[0]=1, word with addr[1:0]!=00 SHALL go IDLE->RESP with err=1, rdata=0, no memory access.
REQ-024 Load or sub-word store SHALL go IDLE->READ; word store SHALL go IDLE->WRITE.
REQ-025 In READ, o_mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}; i_mem_rdata SHALL be captured at the end of the READ cycle; next state RESP for loads, WRITE for stores.
REQ-026 Load extraction: byte lane addr[1:0], halfword lane addr[1]; extend per unsigned flag to 32 bits.
REQ-027 Store merge: replace selected byte/halfword lane of captured word with low bits of wdata; other lanes unchanged; word store uses wdata whole.
REQ-028 In WRITE, o_mem_we SHALL be 1 for exactly one cycle with aligned address and merged data; next state RESP.
REQ-029 o_mem_we SHALL be 0 in every state other than WRITE.
REQ-030 In RESP, o_rsp_valid = 1 with rdata/err stable until i_rsp_ready; on i_rsp_valid & i_rsp_ready go to IDLE.
REQ-031 Latency accept-to-o_rsp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-032 o_mem_addr and o_mem_wdata SHALL be 0 in IDLE and RESP.
REQ-033 A new request SHALL NOT be accepted in the cycle the response is consumed; the earliest next accept is the following cycle.

Reset
REQ-034 While i_rst_n = 0: state IDLE, o_req_ready 1, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0, all latched fields 0.
REQ-035 Reset asserted mid-operation (READ or WRITE) SHALL drop o_mem_we immediately and abandon the request; no memory write occurs after reset deassertion.

Verification
REQ-036 Word load: mem[word 1] = 32'h8000_00F0, lw addr 0x004 -> o_rsp_valid 2 cycles after accept, rdata 32'h8000_00F0, err 0.
REQ-037 Byte loads on the same word: lb addr 0x004 -> 32'hFFFF_FFF0; lbu addr 0x004 -> 32'h0000_00F0; lh addr 0x006 -> 32'hFFFF_8000.
REQ-038 Sub-word store: mem[word 2] = 32'h1122_3344, sb addr 0x009 wdata 32'h0000_00AA -> single o_mem_we pulse with wdata 32'h1122_AA44 at addr 0x008; subsequent lw 0x008 returns 32'h1122_AA44.
REQ-039 Misaligned: sw addr 0x002 -> err 1 one cycle after accept, o_mem_we never 1; lh addr 0x001 -> err 1.
REQ-040 Backpressure: hold i_rsp_ready 0 for 5 cycles in RESP -> rdata/err stable, o_req_ready 0 throughout, single response consumed.
REQ-041 Reset in WRITE of sw addr 0x000 wdata 32'hDEAD_BEEF -> o_mem_we 0 immediately, memory word 0 unchanged, o_req_ready 1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide data memory.
// Sub-word stores use read-modify-write, and loads are extracted and extended per lane.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    req_illegal;

  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extract = uns ? {{(DATA_WIDTH-8){1'b0}}, b}
                                  : {{(DATA_WIDTH-8){b[7]}}, b};
      2'b01:   load_extract = uns ? {{(DATA_WIDTH-16){1'b0}}, h}
                                  : {{(DATA_WIDTH-16){h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    store_merge = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    store_merge[7:0]   = wd[7:0];
          2'd1:    store_merge[15:8]  = wd[7:0];
          2'd2:    store_merge[23:16] = wd[7:0];
          default: store_merge[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) store_merge[31:16] = wd[15:0];
        else         store_merge[15:0]  = wd[15:0];
      end
      default: store_merge = wd;
    endcase
  endfunction

  always_comb begin
    req_illegal = (i_req_size == 2'b11) ||
                  ((i_req_size == 2'b01) && i_req_addr[0]) ||
                  ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          err_d   = req_illegal;
          rdata_d = '0;
          if (req_illegal) begin
            state_d = RESP;
          end else if (i_req_we && (i_req_size == 2'b10)) begin
            // Full-word stores skip the read; nothing to merge.
            mem_data_d = i_req_wdata;
            state_d    = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          mem_data_d = store_merge(i_mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state_d    = WRITE;
        end else begin
          rdata_d = load_extract(i_mem_rdata, size_q, addr_q[1:0], uns_q);
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory outputs decode straight from state so an async reset drops the write at once.
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_rsp_valid = (state_q == RESP);
    o_rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    o_rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    o_mem_we    = (state_q == WRITE);
    o_mem_addr  = ((state_q == READ) || (state_q == WRITE)) ?
                  {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    o_mem_wdata = (state_q == WRITE) ? mem_data_q : '0;
  end

endmodule
